noc_flit_router_port: RTL
=========================

// Module: noc_flit_router_port
// PURPOSE
// - Router input port directly downstream of the NI transmit side: accepts the NI's 8-bit flit stream.
// - Buffers the flits in a small FIFO and decodes the destination from the header flit.
// - Steers the whole packet (header..tail) to one of NUM_PORTS output links; route is held until the tail flit.
// - Packet format: header {HEADER_SIG, dest[1:0]}, 1..4 data flits, tail TAIL_FLIT; max 6 flits.
// PARAMETERS
// - FLIT_W        8          flit width, bits
// - FIFO_DEPTH    4          input buffer entries (power of 2, >=2)
// - NUM_PORTS     4          output links; dest = header[1:0]
// - MAX_PKT_FLITS 6          header + 4 data + tail; length watchdog limit
// PORTS
// - clk        in   1        single clock, rising edge
// - rst_n      in   1        asynchronous active-low reset
// - in_flit    in   FLIT_W   flit from NI
// - in_valid   in   1        in_flit valid
// - in_ready   out  1        port can accept (= FIFO not full); NI's noc_ready
// - out_flit   out  FLIT_W   FIFO head, shared by all output links
// - out_valid  out  NUM_PORTS one-hot; valid on the selected link only
// - out_ready  in   NUM_PORTS per-link ready
// - busy       out  1        packet in progress (state != IDLE)
// - len_err    out  1        1-cycle pulse: tail missing after MAX_PKT_FLITS flits
// - hdr_err    out  1        1-cycle pulse: bad header dropped (HDR_CHECK_EN only)
// BEHAVIOUR
// - Reset (rst_n low, async): FIFO empty, state IDLE, route_sel=0, flit_cnt=0.
//   - Outputs: out_valid=0, busy=0, len_err=0, hdr_err=0, out_flit=0, in_ready=1.
//   - Reset mid-packet discards all buffered flits; no partial packet is resumed.
// - Input handshake: push when in_valid && in_ready. No bypass: flit written in cycle N is poppable in N+1.
// - FIFO: push and pop in the same cycle are legal when non-empty (count unchanged).
//   - Push while full is impossible (in_ready=0). Pointers wrap modulo FIFO_DEPTH.
// - FSM states: IDLE, FWD, DROP.
//   - IDLE: if FIFO non-empty, latch route_sel <= head[1:0], clear flit_cnt, go FWD. No pop; out_valid=0.
//   - FWD: out_valid[route_sel] = !empty; pop when out_ready[route_sel] && !empty; flit_cnt++ per pop.
//     - Popped flit == TAIL_FLIT and flit_cnt != 0 -> IDLE. The header is never treated as a tail.
//     - Pop with flit_cnt == MAX_PKT_FLITS-1 and not a tail -> pulse len_err, go IDLE.
//   - DROP: pop every cycle FIFO is non-empty, out_valid=0; same tail/length exit rules as FWD.
// - Latency: header pushed in cycle N appears with out_valid in N+2; then 1 flit/cycle at full throughput.
// - Idle turnaround: one bubble cycle per packet (IDLE state).
// - out_ready of non-selected links is ignored; out_valid never has more than one bit set.
// - A downstream stall holds out_flit and out_valid stable until accepted.
// CONFIGURATION
// - Macro NOC_HDR_CHECK_EN defined:
//   - In IDLE, if head[7:2] != HEADER_SIG, pulse hdr_err and go DROP instead of FWD.
// - Macro undefined:
//   - Header signature is not checked; every packet is routed by head[1:0]. hdr_err tied 0. DROP is unreachable.
// STRUCTURE
// - Shared package noc_pkg holds FLIT_W, HEADER_SIG (6'b101111), TAIL_FLIT (8'hFF), MAX_PKT_FLITS,
//   and the port-FSM state typedef (IDLE/FWD/DROP).
// - Sub-module flit_fifo: parameterised sync FIFO (DEPTH, WIDTH) with push/pop/full/empty/head.
// - Top: FSM, route register, flit counter, output demux.
// TESTING
// - Reset, then push BE,11,22,33,44,FF with all out_ready=1 -> out_valid=4'b0100;
//   6 flits out in order on consecutive cycles; busy drops after FF.
// - Push BD,AA,FF (1 data flit) -> port 1 gets 3 flits; next packet BC,.. routes to port 0 after 1 idle cycle.
// - Hold out_ready[3]=0 while streaming BF,... -> FIFO fills; in_ready=0 after 4 pushes;
//   out_flit held at BF; release -> drains in order, no loss or duplicate.
// - Push BE,01,02,03,04,05 (no tail) -> len_err pulses on the 6th pop; FSM back to IDLE.
// - Assert rst_n=0 mid-packet after 3 flits -> FIFO empty, out_valid=0 immediately; next packet routes cleanly.
// - With NOC_HDR_CHECK_EN: push 42,11,FF -> hdr_err pulse, 3 flits dropped, out_valid stays 0.

Source files
------------

// File: rtl/noc_flit_router_port_pkg.sv
// Shared definitions for the NoC router input port: flit format constants and port FSM states.
package noc_pkg;

  localparam int unsigned FLIT_W        = 8;
  localparam int unsigned NUM_PORTS     = 4;
  localparam int unsigned FIFO_DEPTH    = 4;
  localparam int unsigned MAX_PKT_FLITS = 6;

  localparam logic [5:0]        HEADER_SIG = 6'b101111;
  localparam logic [FLIT_W-1:0] TAIL_FLIT  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } port_state_e;

  function automatic logic has_header_sig(input logic [FLIT_W-1:0] flit);
    return flit[FLIT_W-1:2] == HEADER_SIG;
  endfunction

endpackage

// File: rtl/noc_flit_router_port_if.sv
// Flit handshake bundle between the NI (master) and the router input port (slave).
interface noc_flit_router_port_if #(
  parameter int unsigned FLIT_W    = 8,
  parameter int unsigned NUM_PORTS = 4
);

  logic [FLIT_W-1:0]    in_flit;
  logic                 in_valid;
  logic                 in_ready;
  logic [FLIT_W-1:0]    out_flit;
  logic [NUM_PORTS-1:0] out_valid;
  logic [NUM_PORTS-1:0] out_ready;

  modport master (
    output in_flit, in_valid, out_ready,
    input  in_ready, out_flit, out_valid
  );

  modport slave (
    input  in_flit, in_valid, out_ready,
    output in_ready, out_flit, out_valid
  );

endinterface

// File: rtl/noc_flit_router_port_fifo.sv
// flit_fifo: small synchronous FIFO, registered head, no write-to-read bypass.
module flit_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_flit_router_port.sv
// Router input port: buffers NI flits, routes each packet by header[1:0] until its tail.
// Optional header signature check enabled by defining NOC_HDR_CHECK_EN.
module noc_flit_router_port
  import noc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = noc_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  noc_flit_router_port_if.slave port,
  output logic                  busy,
  output logic                  len_err,
  output logic                  hdr_err
);

  localparam int unsigned RW = $clog2(NUM_PORTS);
  localparam int unsigned CW = $clog2(MAX_PKT_FLITS);

  port_state_e       state;
  logic [RW-1:0]     route_sel;
  logic [CW-1:0]     flit_cnt;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [FLIT_W-1:0] head;
  logic              is_tail;
  logic              cnt_last;

  assign port.in_ready = !full;
  assign push          = port.in_valid && !full;
  assign port.out_flit = head;
  assign busy          = (state != IDLE);

  // The header always pops at flit_cnt==0, so an FF header cannot close the packet.
  assign is_tail  = (head == TAIL_FLIT) && (flit_cnt != '0);
  assign cnt_last = (flit_cnt == CW'(MAX_PKT_FLITS - 1));

  flit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FLIT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (port.in_flit),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_comb begin
    pop            = 1'b0;
    port.out_valid = '0;
    case (state)
      FWD: begin
        port.out_valid[route_sel] = !empty;
        pop                       = !empty && port.out_ready[route_sel];
      end
      DROP:    pop = !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      route_sel <= '0;
      flit_cnt  <= '0;
      len_err   <= 1'b0;
      hdr_err   <= 1'b0;
    end else begin
      len_err <= 1'b0;
      hdr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            route_sel <= head[RW-1:0];
            flit_cnt  <= '0;
`ifdef NOC_HDR_CHECK_EN
            if (!has_header_sig(head)) begin
              hdr_err <= 1'b1;
              state   <= DROP;
            end else begin
              state <= FWD;
            end
`else
            state <= FWD;
`endif
          end
        end
        FWD, DROP: begin
          if (pop) begin
            flit_cnt <= flit_cnt + CW'(1);
            if (is_tail) begin
              state <= IDLE;
            end else if (cnt_last) begin
              len_err <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
